// File: rtl/ahb_manager_mux.sv
// ahb_manager_mux
// ---------------
// Sits directly after a round-robin arbiter. It pulses arb_enable to request a
// decision and latches the resulting one-hot grant as the address-phase owner.
// It forwards that owner's address/control to the single subordinate port and
// tracks a separate data-phase owner that selects HWDATA. The grant is held
// until the owner's fixed-length burst has been fully accepted and the owner
// drives IDLE.
//
// Ports
//   HCLK, HRESET        bus clock; asynchronous active-high reset
//   m_hbusreq           per-manager request (also forwarded as arb_request)
//   m_htrans/haddr/...  per-manager address phase, packed with manager i in slice i
//   m_hwdata            per-manager write data, packed
//   m_hgrant            one-hot address-phase owner (zero when unowned)
//   m_hready/hrdata/hresp  subordinate response broadcast to all managers
//   arb_request/enable  to the arbiter; arb_grant is its one-hot answer
//   HADDR..HWDATA       subordinate-side address and data phase
//   HREADY/HRDATA/HRESP subordinate response
module ahb_manager_mux #(
  parameter int unsigned MANAGERS = 4,
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32
) (
  input  logic                       HCLK,
  input  logic                       HRESET,
  input  logic [MANAGERS-1:0]        m_hbusreq,
  input  logic [2*MANAGERS-1:0]      m_htrans,
  input  logic [ADDR_W*MANAGERS-1:0] m_haddr,
  input  logic [MANAGERS-1:0]        m_hwrite,
  input  logic [3*MANAGERS-1:0]      m_hsize,
  input  logic [3*MANAGERS-1:0]      m_hburst,
  input  logic [DATA_W*MANAGERS-1:0] m_hwdata,
  output logic [MANAGERS-1:0]        m_hgrant,
  output logic [MANAGERS-1:0]        m_hready,
  output logic [DATA_W-1:0]          m_hrdata,
  output logic                       m_hresp,
  output logic [MANAGERS-1:0]        arb_request,
  output logic                       arb_enable,
  input  logic [MANAGERS-1:0]        arb_grant,
  output logic [ADDR_W-1:0]          HADDR,
  output logic [1:0]                 HTRANS,
  output logic                       HWRITE,
  output logic [2:0]                 HSIZE,
  output logic [2:0]                 HBURST,
  output logic [DATA_W-1:0]          HWDATA,
  input  logic                       HREADY,
  input  logic [DATA_W-1:0]          HRDATA,
  input  logic                       HRESP
);

  localparam logic [1:0] TransIdle   = 2'b00;
  localparam logic [1:0] TransNonseq = 2'b10;
  localparam logic [MANAGERS-1:0] GrantLsb = {{(MANAGERS-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    StArb,
    StWaitGrant,
    StOwned
  } state_e;

  state_e              state_q, state_d;
  logic [MANAGERS-1:0] addr_owner_q, addr_owner_d;
  logic [MANAGERS-1:0] data_owner_q, data_owner_d;
  logic [4:0]          beats_left_q, beats_left_d;
  logic                arb_enable_q, arb_enable_d;

  logic grant_onehot;
  logic xfer_accepted;

  // Beats remaining after the NONSEQ: only HBURST[2:1] matters (wrap and incr
  // variants of a length share the same count; SINGLE and INCR both give 0).
  function automatic logic [4:0] burst_beats(input logic [2:0] hburst);
    logic [4:0] beats;
    case (hburst[2:1])
      2'b00:   beats = 5'd0;
      2'b01:   beats = 5'd3;
      2'b10:   beats = 5'd7;
      default: beats = 5'd15;
    endcase
    return beats;
  endfunction

  // x & (x - 1) clears the lowest set bit; zero result means at most one bit.
  assign grant_onehot = (arb_grant != '0) && ((arb_grant & (arb_grant - GrantLsb)) == '0);

  // Address-phase mux; addr_owner_q is zero outside StOwned, so everything
  // falls back to IDLE/zero with no owner (including immediately on reset).
  always_comb begin
    HADDR  = '0;
    HTRANS = TransIdle;
    HWRITE = 1'b0;
    HSIZE  = '0;
    HBURST = '0;
    HWDATA = '0;
    for (int i = 0; i < int'(MANAGERS); i++) begin
      if (addr_owner_q[i]) begin
        HADDR  = m_haddr[i*ADDR_W +: ADDR_W];
        HTRANS = m_htrans[2*i +: 2];
        HWRITE = m_hwrite[i];
        HSIZE  = m_hsize[3*i +: 3];
        HBURST = m_hburst[3*i +: 3];
      end
      if (data_owner_q[i]) begin
        HWDATA = m_hwdata[i*DATA_W +: DATA_W];
      end
    end
  end

  // NONSEQ or SEQ with the subordinate ready; BUSY never counts.
  assign xfer_accepted = HREADY && HTRANS[1];

  // Ownership FSM.
  always_comb begin
    state_d      = state_q;
    addr_owner_d = addr_owner_q;
    arb_enable_d = 1'b0;
    case (state_q)
      StArb: begin
        if (m_hbusreq != '0) begin
          arb_enable_d = 1'b1;
          state_d      = StWaitGrant;
        end
      end
      StWaitGrant: begin
        if (grant_onehot) begin
          addr_owner_d = arb_grant;
          state_d      = StOwned;
        end else begin
          state_d = StArb;
        end
      end
      StOwned: begin
        if (HREADY && (HTRANS == TransIdle) && (beats_left_q == '0)) begin
          addr_owner_d = '0;
          state_d      = StArb;
        end
      end
      default: begin
        addr_owner_d = '0;
        state_d      = StArb;
      end
    endcase
  end

  // Burst tracking and data-phase ownership; wait states freeze both.
  always_comb begin
    beats_left_d = beats_left_q;
    data_owner_d = data_owner_q;
    if (HREADY) begin
      data_owner_d = xfer_accepted ? addr_owner_q : '0;
      // An ERROR abandons the burst so the owner can release at its next IDLE.
      if (HRESP) begin
        beats_left_d = '0;
      end else if (xfer_accepted && (HTRANS == TransNonseq)) begin
        beats_left_d = burst_beats(HBURST);
      end else if (xfer_accepted && (beats_left_q != '0)) begin
        beats_left_d = beats_left_q - 5'd1;
      end
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q      <= StArb;
      addr_owner_q <= '0;
      data_owner_q <= '0;
      beats_left_q <= '0;
      arb_enable_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_owner_q <= addr_owner_d;
      data_owner_q <= data_owner_d;
      beats_left_q <= beats_left_d;
      arb_enable_q <= arb_enable_d;
    end
  end

  assign m_hgrant    = addr_owner_q;
  assign arb_enable  = arb_enable_q;
  assign arb_request = m_hbusreq;
  assign m_hready    = {MANAGERS{HREADY}};
  assign m_hrdata    = HRDATA;
  assign m_hresp     = HRESP;

endmodule
